// File: rtl/water_level_sensor_ctrl.sv
// Tank level front end: 2-flop probe synchroniser, debounce, thermometer-to-BCD encode,
// and the pump FSM with low/high hysteresis, dry-fill timeout and sensor-fault latch.
module water_level_sensor_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned LOW_LEVEL       = 2,
  parameter int unsigned HIGH_LEVEL      = 8,
  parameter int unsigned FILL_TIMEOUT    = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] probe,
  input  logic       fault_clr,
  output logic [3:0] level_bcd,
  output logic       level_valid,
  output logic       pump_on,
  output logic       fault
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [3:0] LOW_L = 4'(LOW_LEVEL);
  localparam logic [3:0] HIGH_L = 4'(HIGH_LEVEL);
  localparam logic [31:0] TIMEOUT_LAST = 32'(FILL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FAULT = 2'd2
  } state_t;

  logic [8:0]    sync1;
  logic [8:0]    sync2;
  logic [8:0]    cand;
  logic [8:0]    stable;
  logic          stable_vld;
  logic [CW-1:0] db_cnt;
  logic          sens_err;
  logic [3:0]    level_prev;
  logic [31:0]   fill_timer;
  logic          code_ok;
  logic [3:0]    ones;
  state_t        state;
  state_t        state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      cand       <= '0;
      stable     <= '0;
      stable_vld <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync1 <= probe;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand   <= sync2;
        db_cnt <= '0;
      end else if (db_cnt != DB_MAX) begin
        db_cnt <= db_cnt + CW'(1);
      end
      if (db_cnt == DB_MAX) begin
        stable     <= cand;
        stable_vld <= 1'b1;
      end
    end
  end

  // A legal thermometer code has no 1 above a 0, i.e. stable+1 is a power of two (or wraps to 0).
  always_comb begin
    code_ok = ((stable & (stable + 9'd1)) == 9'd0);
    ones    = 4'd0;
    for (int i = 0; i < 9; i++) begin
      ones = ones + {3'd0, stable[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_bcd   <= 4'd0;
      level_valid <= 1'b0;
      sens_err    <= 1'b0;
      level_prev  <= 4'd0;
    end else begin
      level_bcd   <= code_ok ? ones : 4'hF;
      sens_err    <= !code_ok;
      level_valid <= level_valid | stable_vld;
      level_prev  <= level_bcd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pump_on    = 1'b0;
    fault      = 1'b0;
    case (state)
      FILL:    pump_on = 1'b1;
      FAULT:   fault   = 1'b1;
      default: ;
    endcase
    if (sens_err) begin
      state_next = FAULT;
    end else begin
      case (state)
        IDLE: begin
          if (level_valid && (level_bcd <= LOW_L)) state_next = FILL;
        end
        FILL: begin
          // Reaching the stop level wins over a coincident timeout.
          if (level_bcd >= HIGH_L) state_next = IDLE;
          else if (fill_timer == TIMEOUT_LAST) state_next = FAULT;
        end
        FAULT: begin
          if (fault_clr) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_timer <= 32'd0;
    end else if (state_next != FILL || state != FILL) begin
      fill_timer <= 32'd0;
    end else if (level_bcd > level_prev) begin
      fill_timer <= 32'd0;
    end else begin
      fill_timer <= fill_timer + 32'd1;
    end
  end

endmodule
